// File: rtl/tail_light_pkg.sv
// Shared lamp-bus pattern constants and defaults for the tail light decoder.
package tail_light_pkg;

  // Left bus is {c,b,a}; right bus is {a,b,c}, so partial codes fill from opposite ends.
  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_A   = 3'b001;
  localparam logic [2:0] L_AB  = 3'b011;
  localparam logic [2:0] L_ALL = 3'b111;
  localparam logic [2:0] R_OFF = 3'b000;
  localparam logic [2:0] R_A   = 3'b100;
  localparam logic [2:0] R_AB  = 3'b110;
  localparam logic [2:0] R_ALL = 3'b111;

  localparam int HOLD_DEFAULT = 3;

endpackage

// File: rtl/tail_light_side_tracker.sv
// One side of the lamp bus: code legality, sweep step check and turn hold counter.
module tail_light_side_tracker
  import tail_light_pkg::*;
#(
  parameter bit MIRROR = 1'b0,
  parameter int HOLD   = HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] code,
  output logic       is_partial,
  output logic       is_all,
  output logic       is_off,
  output logic       err,
  output logic       active
);

  localparam logic [2:0] C_OFF = MIRROR ? R_OFF : L_OFF;
  localparam logic [2:0] C_A   = MIRROR ? R_A   : L_A;
  localparam logic [2:0] C_AB  = MIRROR ? R_AB  : L_AB;
  localparam logic [2:0] C_ALL = MIRROR ? R_ALL : L_ALL;

  logic [2:0] prev_q;
  logic [2:0] hold_q, hold_d;
  logic       legal, step_bad;

  assign legal      = (code == C_OFF) || (code == C_A) || (code == C_AB) || (code == C_ALL);
  assign step_bad   = (code == C_AB) && (prev_q != C_A);
  assign err        = !legal || step_bad;
  assign is_partial = (code == C_A) || (code == C_AB);
  assign is_all     = (code == C_ALL);
  assign is_off     = (code == C_OFF);
  assign active     = (hold_q != 3'd0);

  // A partial reached by an illegal step is not trusted as a turn indication.
  always_comb begin
    hold_d = hold_q;
    if (is_partial && !err)    hold_d = 3'(HOLD);
    else if (hold_q != 3'd0)   hold_d = hold_q - 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= C_OFF;
      hold_q <= 3'd0;
    end else begin
      prev_q <= code;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/tail_light_decoder.sv
// Lamp-bus receive decoder: turn, brake and hazard intent plus error tracking.
module tail_light_decoder
  import tail_light_pkg::*;
#(
  parameter int HOLD  = HOLD_DEFAULT,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       Lcba,
  input  logic [2:0]       Rabc,
  output logic             brake_det,
  output logic             hazard_det,
  output logic             left_det,
  output logic             right_det,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  logic l_part, l_all, l_off, l_err;
  logic r_part, r_all, r_off, r_err;

  tail_light_side_tracker #(.MIRROR(1'b0), .HOLD(HOLD)) u_left (
    .clk(clk), .reset(reset), .code(Lcba),
    .is_partial(l_part), .is_all(l_all), .is_off(l_off), .err(l_err), .active(left_det)
  );

  tail_light_side_tracker #(.MIRROR(1'b1), .HOLD(HOLD)) u_right (
    .clk(clk), .reset(reset), .code(Rabc),
    .is_partial(r_part), .is_all(r_all), .is_off(r_off), .err(r_err), .active(right_det)
  );

  logic             both_all, both_off, err_any;
  logic             prev_all_q, prev_lit_q;
  logic             brake_q, brake_d;
  logic [1:0]       alt_q, alt_d;
  logic             seq_err_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  assign both_all = l_all && r_all;
  assign both_off = l_off && r_off;
  assign err_any  = l_err || r_err;

  // prev_lit_q is "previous sample not all-off", so its reset value of 0 means 000/000.
  always_comb begin
    brake_d   = (l_part && r_all) || (r_part && l_all) || (both_all && prev_all_q);
    alt_d     = 2'd0;
    if ((both_all && !prev_lit_q) || (both_off && prev_all_q))
      alt_d = (alt_q == 2'd2) ? 2'd2 : alt_q + 2'd1;
    err_cnt_d = err_cnt_q;
    if (err_any && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_all_q <= 1'b0;
      prev_lit_q <= 1'b0;
      brake_q    <= 1'b0;
      alt_q      <= 2'd0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      prev_all_q <= both_all;
      prev_lit_q <= !both_off;
      brake_q    <= brake_d;
      alt_q      <= alt_d;
      seq_err_q  <= err_any;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign brake_det  = brake_q;
  assign hazard_det = (alt_q == 2'd2);
  assign seq_err    = seq_err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// Randomised and directed checks of tail_light_decoder against a sample-history model.
module tb_tail_light_decoder;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] Lcba = 3'b000, Rabc = 3'b000;
  logic       brake_det, hazard_det, left_det, right_det, seq_err;
  logic [7:0] err_count;
  logic       brake2, hazard2, left2, right2, seq2;
  logic [1:0] err_count2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tail_light_decoder #(.HOLD(HOLD), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .Lcba(Lcba), .Rabc(Rabc),
    .brake_det(brake_det), .hazard_det(hazard_det), .left_det(left_det),
    .right_det(right_det), .seq_err(seq_err), .err_count(err_count)
  );

  tail_light_decoder #(.HOLD(HOLD), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .Lcba(Lcba), .Rabc(Rabc),
    .brake_det(brake2), .hazard_det(hazard2), .left_det(left2),
    .right_det(right2), .seq_err(seq2), .err_count(err_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: previous sample, edges since last trusted partial, alternation run length, error total.
  int mpL, mpR, sinceL, sinceR, run, errs;
  int mL, mR;
  bit eL, eR, pL, pR, alt;
  bit e_left, e_right, e_brake, e_haz, e_seq;

  always @(negedge clk) begin
    if (reset) begin
      mpL = 0; mpR = 0; sinceL = 100; sinceR = 100; run = 0; errs = 0;
      e_left = 0; e_right = 0; e_brake = 0; e_haz = 0; e_seq = 0;
      chk("rst_outs", {brake_det, hazard_det, left_det, right_det, seq_err}, 0);
      chk("rst_cnt", {err_count, err_count2}, 0);
    end else begin
      mL = int'(Lcba); mR = int'(Rabc);
      eL = !(mL inside {0, 1, 3, 7}) || (mL == 3 && mpL != 1);
      eR = !(mR inside {0, 4, 6, 7}) || (mR == 6 && mpR != 4);
      pL = (mL == 1 || mL == 3);
      pR = (mR == 4 || mR == 6);
      sinceL = (pL && !eL) ? 0 : ((sinceL < 100) ? sinceL + 1 : 100);
      sinceR = (pR && !eR) ? 0 : ((sinceR < 100) ? sinceR + 1 : 100);
      e_left  = sinceL < HOLD;
      e_right = sinceR < HOLD;
      e_brake = (pL && mR == 7) || (pR && mL == 7) || (mL == 7 && mR == 7 && mpL == 7 && mpR == 7);
      alt = (mL == 7 && mR == 7 && mpL == 0 && mpR == 0) || (mL == 0 && mR == 0 && mpL == 7 && mpR == 7);
      run = alt ? ((run < 100) ? run + 1 : 100) : 0;
      e_haz = run >= 2;
      e_seq = eL || eR;
      if (e_seq) errs++;
      mpL = mL; mpR = mR;
      chk("left_det", left_det, e_left);
      chk("right_det", right_det, e_right);
      chk("brake_det", brake_det, e_brake);
      chk("hazard_det", hazard_det, e_haz);
      chk("seq_err", seq_err, e_seq);
      chk("err_count", err_count, (errs > 255) ? 255 : errs);
      chk("err_count_w2", err_count2, (errs > 3) ? 3 : errs);
      chk("seq_err_w2", seq2, e_seq);
    end
  end

  // Drive a sample just after the falling edge; return just after the edge that samples it.
  task automatic step(input logic [2:0] l, input logic [2:0] r);
    @(negedge clk); #1;
    Lcba = l; Rabc = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; Lcba = 3'b000; Rabc = 3'b000;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  int r8;
  logic [2:0] lc, rc;
  logic [2:0] lleg [4];
  logic [2:0] rleg [4];

  initial begin
    lleg = '{3'b000, 3'b001, 3'b011, 3'b111};
    rleg = '{3'b000, 3'b100, 3'b110, 3'b111};
    repeat (3) @(posedge clk);
    #1;
    chk("pin_reset_state", {brake_det, hazard_det, left_det, right_det, seq_err, err_count}, 0);
    @(negedge clk); #1;
    reset = 1'b0;

    // Left sweep with right side dark
    for (int k = 0; k < 4; k++) begin
      step(3'b001, 3'b000);
      if (k == 0) chk("pin_left_first", {left_det, right_det, brake_det, hazard_det}, 4'b1000);
      step(3'b011, 3'b000);
      step(3'b111, 3'b000);
      step(3'b000, 3'b000);
    end
    chk("pin_left_2after", left_det, 1);
    step(3'b000, 3'b000);
    chk("pin_left_3after", left_det, 0);
    step(3'b000, 3'b000);

    // Right sweep while braking
    step(3'b111, 3'b100);
    chk("pin_right_brake", {right_det, brake_det, hazard_det, seq_err}, 4'b1100);
    for (int k = 0; k < 4; k++) begin
      step(3'b111, 3'b110);
      step(3'b111, 3'b111);
      step(3'b111, 3'b100);
    end
    chk("pin_right_err", err_count, 0);

    // Hazard alternation after a non-alternating sample
    step(3'b111, 3'b000);
    for (int k = 0; k < 8; k++) begin
      step((k % 2 == 0) ? 3'b111 : 3'b000, (k % 2 == 0) ? 3'b111 : 3'b000);
      chk("pin_hazard_seq", hazard_det, (k >= 2) ? 1 : 0);
    end
    step(3'b111, 3'b111);
    step(3'b111, 3'b111);
    chk("pin_hold_all", {hazard_det, brake_det}, 2'b01);

    // Illegal codes and steps
    do_reset();
    step(3'b010, 3'b000);
    chk("pin_illegal_code", {seq_err, err_count}, {1'b1, 8'd1});
    step(3'b000, 3'b000);
    chk("pin_err_clear", seq_err, 0);
    step(3'b011, 3'b000);
    chk("pin_illegal_step", {seq_err, left_det, err_count}, {2'b10, 8'd2});
    step(3'b010, 3'b000);
    step(3'b000, 3'b101);
    step(3'b101, 3'b010);
    chk("pin_err5", err_count, 5);
    chk("pin_err_sat_w2", err_count2, 3);
    step(3'b001, 3'b000);
    chk("pin_pre_reset", {left_det, seq_err}, 2'b10);

    // Asynchronous reset mid-sweep
    #2 reset = 1'b1;
    #1 chk("pin_async_reset", {left_det, err_count, err_count2, seq_err}, 0);
    @(negedge clk); #1;
    reset = 1'b0; Lcba = 3'b011; Rabc = 3'b000;
    @(posedge clk); #1;
    chk("pin_after_reset", {seq_err, left_det, err_count}, {2'b10, 8'd1});

    // Randomised traffic biased toward legal codes and hazard-style samples
    for (int k = 0; k < 1500; k++) begin
      r8 = int'($urandom_range(0, 9));
      if (r8 < 3) begin
        lc = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
        rc = lc;
      end else begin
        lc = (r8 == 9) ? 3'($urandom) : lleg[$urandom_range(0, 3)];
        rc = ($urandom_range(0, 9) == 0) ? 3'($urandom) : rleg[$urandom_range(0, 3)];
      end
      step(lc, rc);
      if (k == 750) do_reset();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
